// File: rtl/octave_scan_ctrl_if.sv
// Pixel handshake, stage drive and output-grid bus for octave_scan_ctrl.
// OCT_SCAN_STALL_CNT_EN adds the stall_cnt observation signal.
interface octave_scan_ctrl_if #(parameter int DATA_W = 8);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              oct_en;
    logic [DATA_W-1:0] oct_data;
    logic [9:0]        oct_x;
    logic [9:0]        oct_y;
    logic              out_valid;
    logic [9:0]        out_x;
    logic [9:0]        out_y;
`ifdef OCT_SCAN_STALL_CNT_EN
    logic [15:0]       stall_cnt;

    modport master (output start, abort, pix_valid, pix_data,
                    input  busy, done, pix_ready, oct_en, oct_data, oct_x, oct_y,
                           out_valid, out_x, out_y, stall_cnt);
    modport slave  (input  start, abort, pix_valid, pix_data,
                    output busy, done, pix_ready, oct_en, oct_data, oct_x, oct_y,
                           out_valid, out_x, out_y, stall_cnt);
`else
    modport master (output start, abort, pix_valid, pix_data,
                    input  busy, done, pix_ready, oct_en, oct_data, oct_x, oct_y,
                           out_valid, out_x, out_y);
    modport slave  (input  start, abort, pix_valid, pix_data,
                    output busy, done, pix_ready, oct_en, oct_data, oct_x, oct_y,
                           out_valid, out_x, out_y);
`endif
endinterface

// File: rtl/octave_scan_ctrl.sv
// Frame sequencer in front of one octave Gaussian stage: scans, drains with zeros, and
// emits latency-aligned output-grid strobes. OCT_SCAN_STALL_CNT_EN adds stall_cnt.
module octave_scan_ctrl #(
    parameter int DATA_W   = 8,
    parameter int FRAME_W  = 640,
    parameter int FRAME_H  = 480,
    parameter int DOWN_S   = 0,
    parameter int PIPE_LAT = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    octave_scan_ctrl_if.slave bus
);
    localparam int OUT_W = FRAME_W >> DOWN_S;
    localparam int OUT_H = FRAME_H >> DOWN_S;
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int LAT_W = $clog2(PIPE_LAT + 1);

    localparam logic [9:0]       X_MAX    = 10'(FRAME_W - 1);
    localparam logic [9:0]       Y_MAX    = 10'(FRAME_H - 1);
    localparam logic [9:0]       OX_MAX   = 10'(OUT_W - 1);
    localparam logic [9:0]       DEC_MASK = 10'((1 << DOWN_S) - 1);
    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(TOTAL - 1);
    localparam logic [LAT_W-1:0] LAT_C    = LAT_W'(PIPE_LAT);
    localparam logic [LAT_W:0]   LAT_CMP  = (LAT_W+1)'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t           state;
    logic [LAT_W-1:0] latCnt;
    logic [CNT_W-1:0] outCnt;
    logic             dec;
    logic             latReached;
    logic             lastPix;
    logic             lastOut;
    logic             clr;

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.pix_ready = (state == SCAN);
    assign bus.oct_en    = ((state == SCAN) && bus.pix_valid) || (state == FLUSH);
    assign bus.oct_data  = (state == SCAN) ? bus.pix_data : '0;

    // The current decimated sample counts toward the latency, so the strobe fires on
    // the PIPE_LAT-th decimated enable.
    assign dec        = bus.oct_en && ((bus.oct_x & DEC_MASK) == '0) && ((bus.oct_y & DEC_MASK) == '0);
    assign latReached = (({1'b0, latCnt} + 1'b1) >= LAT_CMP);
    assign bus.out_valid = dec && latReached && (outCnt < TOTAL_C);

    assign lastPix = (bus.oct_x == X_MAX) && (bus.oct_y == Y_MAX);
    assign lastOut = bus.out_valid && (outCnt == TOTAL_M1);
    assign clr     = bus.abort || ((state == IDLE) && bus.start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  if (bus.start) state <= SCAN;
                SCAN: begin
                    if (lastOut)                          state <= DONE;
                    else if (bus.pix_valid && lastPix)    state <= FLUSH;
                end
                FLUSH: if (lastOut) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.oct_x <= '0;
            bus.oct_y <= '0;
            bus.out_x <= '0;
            bus.out_y <= '0;
            latCnt    <= '0;
            outCnt    <= '0;
        end else if (clr) begin
            bus.oct_x <= '0;
            bus.oct_y <= '0;
            bus.out_x <= '0;
            bus.out_y <= '0;
            latCnt    <= '0;
            outCnt    <= '0;
        end else begin
            // oct_y deliberately runs past the frame during the drain.
            if (bus.oct_en) begin
                if (bus.oct_x == X_MAX) begin
                    bus.oct_x <= '0;
                    bus.oct_y <= bus.oct_y + 10'd1;
                end else begin
                    bus.oct_x <= bus.oct_x + 10'd1;
                end
            end
            if (dec && (latCnt != LAT_C)) latCnt <= latCnt + 1'b1;
            if (bus.out_valid) begin
                outCnt <= outCnt + 1'b1;
                if (bus.out_x == OX_MAX) begin
                    bus.out_x <= '0;
                    bus.out_y <= bus.out_y + 10'd1;
                end else begin
                    bus.out_x <= bus.out_x + 10'd1;
                end
            end
        end
    end

`ifdef OCT_SCAN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.stall_cnt <= '0;
        else if (!bus.abort && (state == IDLE) && bus.start)
            bus.stall_cnt <= '0;
        else if ((state == SCAN) && !bus.pix_valid && (bus.stall_cnt != 16'hFFFF))
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_octave_scan_ctrl.sv
// Randomized bench: two controllers (no decimation and /2) share one stimulus stream and
// are checked every cycle against an arithmetic raster/latency model.
module tb_octave_scan_ctrl;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, pixValid;
    logic [7:0] pixData;

    int nChecks = 0;
    int nErrors = 0;

    int mPh[2], mPos[2], mDec[2], mOut[2], mStall[2];

    always #5 clk = ~clk;

    octave_scan_ctrl_if #(.DATA_W(8)) b0();
    octave_scan_ctrl_if #(.DATA_W(8)) b1();

    assign b0.start = start;  assign b0.abort = abort;
    assign b0.pix_valid = pixValid;  assign b0.pix_data = pixData;
    assign b1.start = start;  assign b1.abort = abort;
    assign b1.pix_valid = pixValid;  assign b1.pix_data = pixData;

    octave_scan_ctrl #(.DATA_W(8), .FRAME_W(W), .FRAME_H(H), .DOWN_S(0), .PIPE_LAT(LAT))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    octave_scan_ctrl #(.DATA_W(8), .FRAME_W(W), .FRAME_H(H), .DOWN_S(1), .PIPE_LAT(LAT))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input longint got, input longint exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic resetModel(input int k);
        mPh[k] = 0; mPos[k] = 0; mDec[k] = 0; mOut[k] = 0; mStall[k] = 0;
    endtask

    // Phase codes: 0 idle, 1 scan, 2 flush, 3 done.
    task automatic evalDut(input int k, input logic busy, input logic done, input logic rdy,
                           input logic en, input logic [7:0] od, input logic [9:0] ox,
                           input logic [9:0] oy, input logic ov, input logic [9:0] qx,
                           input logic [9:0] qy, input logic [15:0] sc);
        int ow, total, x, y, step;
        logic eEn, eDec, eOv;
        string p;
        step  = 1 << k;
        ow    = W >> k;
        total = ow * (H >> k);
        p     = $sformatf("u%0d.", k);
        if (!rst_n) resetModel(k);
        x    = mPos[k] % W;
        y    = (mPos[k] / W) % 1024;
        eEn  = (mPh[k] == 1 && pixValid) || mPh[k] == 2;
        eDec = eEn && (x % step == 0) && (y % step == 0);
        eOv  = eDec && (mDec[k] + 1 >= LAT) && (mOut[k] < total);
        chk({p, "busy"},      busy, mPh[k] != 0);
        chk({p, "done"},      done, mPh[k] == 3);
        chk({p, "pix_ready"}, rdy,  mPh[k] == 1);
        chk({p, "oct_en"},    en,   eEn);
        chk({p, "oct_data"},  od,   (mPh[k] == 1) ? pixData : 8'd0);
        chk({p, "oct_x"},     ox,   x);
        chk({p, "oct_y"},     oy,   y);
        chk({p, "out_valid"}, ov,   eOv);
        chk({p, "out_x"},     qx,   mOut[k] % ow);
        chk({p, "out_y"},     qy,   mOut[k] / ow);
`ifdef OCT_SCAN_STALL_CNT_EN
        chk({p, "stall_cnt"}, sc,   mStall[k]);
`else
        if (sc != 16'd0) chk({p, "stall_tie"}, sc, 0);
`endif
        if (rst_n) begin
            if (abort) begin
                mPh[k] = 0; mPos[k] = 0; mDec[k] = 0; mOut[k] = 0;
            end else begin
                case (mPh[k])
                    0: if (start) begin
                        mPh[k] = 1; mPos[k] = 0; mDec[k] = 0; mOut[k] = 0; mStall[k] = 0;
                    end
                    1, 2: begin
                        if (mPh[k] == 1 && !pixValid && mStall[k] < 65535) mStall[k]++;
                        if (eEn)  mPos[k]++;
                        if (eDec) mDec[k]++;
                        if (eOv)  mOut[k]++;
                        if (eOv && mOut[k] == total) mPh[k] = 3;
                        else if (mPh[k] == 1 && mPos[k] == W * H) mPh[k] = 2;
                    end
                    default: mPh[k] = 0;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
`ifdef OCT_SCAN_STALL_CNT_EN
        evalDut(0, b0.busy, b0.done, b0.pix_ready, b0.oct_en, b0.oct_data, b0.oct_x, b0.oct_y,
                b0.out_valid, b0.out_x, b0.out_y, b0.stall_cnt);
        evalDut(1, b1.busy, b1.done, b1.pix_ready, b1.oct_en, b1.oct_data, b1.oct_x, b1.oct_y,
                b1.out_valid, b1.out_x, b1.out_y, b1.stall_cnt);
`else
        evalDut(0, b0.busy, b0.done, b0.pix_ready, b0.oct_en, b0.oct_data, b0.oct_x, b0.oct_y,
                b0.out_valid, b0.out_x, b0.out_y, 16'd0);
        evalDut(1, b1.busy, b1.done, b1.pix_ready, b1.oct_en, b1.oct_data, b1.oct_x, b1.oct_y,
                b1.out_valid, b1.out_x, b1.out_y, 16'd0);
`endif
    end

    task automatic drive(input logic s, input logic a, input logic pv, input logic r);
        @(posedge clk);
        #1;
        start = s; abort = a; pixValid = pv; rst_n = r;
        pixData = 8'($urandom);
    endtask

    // mode 0: pix_valid held high, 1: alternating from the first scan cycle, 2: random.
    task automatic frame(input int mode, input int abortAt, input bit rstInFlush);
        int t;
        logic pv, s, a, r;
        bit finished;
        finished = 0;
        t = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            case (mode)
                0:       pv = 1'b1;
                1:       pv = (t % 2 == 0);
                default: pv = 1'($urandom_range(0, 1));
            endcase
            t++;
            s = (mPh[0] != 0 && mPh[1] != 0) && ($urandom_range(0, 7) == 0);
            a = (abortAt >= 0) && (mPh[0] == 1) && (mPos[0] == abortAt);
            r = !(rstInFlush && mPh[0] == 2);
            drive(s, a, pv, r);
            @(negedge clk);
            #1;
            if (mPh[0] == 0 && mPh[1] == 0) begin
                finished = 1;
                break;
            end
        end
        if (!finished) chk("frame_timeout", 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pixValid = 1'b0; pixData = 8'd0;
        resetModel(0);
        resetModel(1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1);
        frame(0, -1, 0);
        frame(1, -1, 0);
        frame(0, 19, 0);
        frame(0, -1, 0);
        for (int i = 0; i < 4; i++) frame(2, -1, 0);
        frame(0, -1, 1);
        frame(2, -1, 0);
        repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
